// File: rtl/meta_array_1r1w.sv
// Parametrised 1-read/1-write metadata array with per-lane write masks, per-entry
// valid bits and occupancy count, optional write-to-read forwarding, and a clear sequencer.
module meta_array_1r1w #(
  parameter int DEPTH  = 40,
  parameter int WIDTH  = 240,
  parameter int LANES  = 4,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [LANES-1:0] W0_mask,
  input  logic [WIDTH-1:0] W0_data,
  input  logic             flush,
  output logic             busy,
  output logic [CW-1:0]    count
);
  localparam int LW = WIDTH / LANES;
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [DEPTH-1:0] valid;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_fire;
  logic             fwd;
  logic [AW-1:0]    raddr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rd_next;

  assign busy        = (state == CLEAR);
  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_EXT);
  // A flush in the same cycle wins over the write; an all-zero mask is a no-op.
  assign wr_fire     = ~busy & ~flush & W0_en & wr_in_range & (|W0_mask);
  assign fwd         = (BYPASS != 0) && wr_fire && (W0_addr == R0_addr);
  assign raddr       = rd_in_range ? R0_addr : '0;
  // The clear sequencer shares the single write port with the pipeline writer.
  assign waddr       = busy ? idx : W0_addr;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LW-1:0] lane_mem [DEPTH];
    logic          lane_we;
    logic [LW-1:0] lane_wdata;

    assign lane_we    = busy | (wr_fire & W0_mask[gi]);
    assign lane_wdata = busy ? '0 : W0_data[gi*LW +: LW];

    always_ff @(posedge clock) begin
      if (lane_we) begin
        lane_mem[waddr] <= lane_wdata;
      end
    end

    assign rd_next[gi*LW +: LW] = (fwd && W0_mask[gi]) ? W0_data[gi*LW +: LW]
                                                        : lane_mem[raddr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      idx      <= '0;
      valid    <= '0;
      count    <= '0;
      R0_data  <= '0;
      R0_valid <= 1'b0;
    end else begin
      if (flush) begin
        state <= CLEAR;
        idx   <= '0;
        valid <= '0;
        count <= '0;
      end else if (state == CLEAR) begin
        valid[idx] <= 1'b0;
        if (idx == LAST_IDX) begin
          state <= IDLE;
        end else begin
          idx <= idx + AW'(1);
        end
      end else if (wr_fire) begin
        valid[W0_addr] <= 1'b1;
        if (!valid[W0_addr]) begin
          count <= count + CW'(1);
        end
      end

      if (R0_en) begin
        if (busy || !rd_in_range) begin
          R0_data  <= '0;
          R0_valid <= 1'b0;
        end else begin
          R0_data  <= rd_next;
          R0_valid <= fwd ? 1'b1 : valid[raddr];
        end
      end
    end
  end
endmodule

// File: tb/tb_meta_array_1r1w.sv
// Bench for meta_array_1r1w: one forwarding and one non-forwarding instance share
// stimulus; a reference model pushes expected reads into a scoreboard queue.
module tb_meta_array_1r1w;
  localparam int DEPTH = 40;
  localparam int WIDTH = 240;
  localparam int LANES = 4;
  localparam int AW    = 6;
  localparam int CW    = 6;
  localparam int LW    = WIDTH / LANES;

  logic             clock = 1'b0;
  logic             reset;
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [LANES-1:0] W0_mask;
  logic [WIDTH-1:0] W0_data;
  logic             flush;

  logic [WIDTH-1:0] rd_b, rd_nb;
  logic             rv_b, rv_nb, busy_b, busy_nb;
  logic [CW-1:0]    cnt_b, cnt_nb;

  meta_array_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_b), .R0_valid(rv_b),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_mask(W0_mask), .W0_data(W0_data),
    .flush(flush), .busy(busy_b), .count(cnt_b)
  );

  meta_array_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_nb), .R0_valid(rv_nb),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_mask(W0_mask), .W0_data(W0_data),
    .flush(flush), .busy(busy_nb), .count(cnt_nb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] d_b;
    logic             v_b;
    logic [WIDTH-1:0] d_nb;
    logic             v_nb;
  } rd_exp_t;

  rd_exp_t          sb[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_valid [DEPTH];
  int               m_count;
  int               m_idx;
  logic             m_busy;
  int               checks = 0;
  int               passed = 0;
  int               cyc = 0;

  function automatic logic [WIDTH-1:0] rnd_data();
    return WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    m_busy  = 1'b1;
    m_idx   = 0;
    m_count = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Applies one cycle of stimulus, predicts the read result, advances the model.
  task automatic drive(input logic ren, input int raddr, input logic wen, input int waddr,
                       input logic [LANES-1:0] mask, input logic [WIDTH-1:0] wdata,
                       input logic fl);
    rd_exp_t e;
    logic    wr_ok;
    R0_en = ren; R0_addr = AW'(raddr);
    W0_en = wen; W0_addr = AW'(waddr); W0_mask = mask; W0_data = wdata;
    flush = fl;
    wr_ok = wen && !m_busy && !fl && (waddr < DEPTH) && (mask != '0);
    if (ren) begin
      e = '{default: '0};
      if (!m_busy && raddr < DEPTH) begin
        e.d_nb = m_mem[raddr];
        e.v_nb = m_valid[raddr];
        e.d_b  = e.d_nb;
        e.v_b  = e.v_nb;
        if (wr_ok && waddr == raddr) begin
          for (int l = 0; l < LANES; l++)
            if (mask[l]) e.d_b[l*LW +: LW] = wdata[l*LW +: LW];
          e.v_b = 1'b1;
        end
      end
      sb.push_back(e);
    end
    if (fl) begin
      m_busy = 1'b1; m_idx = 0; m_count = 0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else if (m_busy) begin
      m_mem[m_idx] = '0; m_valid[m_idx] = 1'b0;
      if (m_idx == DEPTH - 1) m_busy = 1'b0;
      else m_idx++;
    end else if (wr_ok) begin
      for (int l = 0; l < LANES; l++)
        if (mask[l]) m_mem[waddr][l*LW +: LW] = wdata[l*LW +: LW];
      if (!m_valid[waddr]) m_count++;
      m_valid[waddr] = 1'b1;
    end
    $display("cyc %0d: ren=%0b ra=%0d wen=%0b wa=%0d mask=%b flush=%0b", cyc, ren, raddr,
             wen, waddr, mask, fl);
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rd_exp_t e;
    int edges;
    reset = 1'b1; R0_en = 0; R0_addr = '0; W0_en = 0; W0_addr = '0;
    W0_mask = '0; W0_data = '0; flush = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy_b !== 1'b1 || busy_nb !== 1'b1 || cnt_b !== '0 || cnt_nb !== '0 ||
        rd_b !== '0 || rv_b !== 1'b0 || rd_nb !== '0 || rv_nb !== 1'b0)
      $display("FAIL reset_state: busy=%b/%b count=%0d/%0d rv=%b/%b expected busy=1 count=0 rv=0",
               busy_b, busy_nb, cnt_b, cnt_nb, rv_b, rv_nb);
    else passed++;
    reset = 1'b0;
    model_reset();
    edges = 0;
    while (busy_b === 1'b1 && edges < 100) begin
      drive(1, 5, 0, 0, '0, '0, 0);
      edges++;
      e = sb.pop_front();
      checks++;
      if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb ||
          busy_b !== m_busy || busy_nb !== m_busy)
        $display("FAIL reset_clear_read: got %h/%b busy=%b expected %h/%b busy=%b",
                 rd_b, rv_b, busy_b, e.d_b, e.v_b, m_busy);
      else passed++;
    end
    checks++;
    if (edges != DEPTH) $display("FAIL reset_busy_len: got %0d expected %0d", edges, DEPTH);
    else passed++;
    checks++;
    if (cnt_b !== '0 || cnt_nb !== '0)
      $display("FAIL reset_count: got %0d/%0d expected 0", cnt_b, cnt_nb);
    else passed++;
  endtask

  task automatic test_mask();
    rd_exp_t e;
    logic [WIDTH-1:0] a5, s5a, want;
    a5  = {30{8'hA5}};
    s5a = {30{8'h5A}};
    drive(0, 0, 1, 3, 4'b1111, a5, 0);
    drive(0, 0, 1, 3, 4'b0101, s5a, 0);
    drive(1, 3, 0, 0, '0, '0, 0);
    e = sb.pop_front();
    want = a5;
    want[0 +: LW]    = s5a[0 +: LW];
    want[2*LW +: LW] = s5a[2*LW +: LW];
    checks++;
    if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb)
      $display("FAIL mask_read_sb: got %h/%b expected %h/%b", rd_b, rv_b, e.d_b, e.v_b);
    else passed++;
    checks++;
    if (rd_b !== want || rd_nb !== want || rv_b !== 1'b1 || rv_nb !== 1'b1)
      $display("FAIL mask_merge: got %h/%b expected %h/1", rd_nb, rv_nb, want);
    else passed++;
    checks++;
    if (cnt_b !== CW'(1) || cnt_nb !== CW'(1))
      $display("FAIL mask_count: got %0d/%0d expected 1", cnt_b, cnt_nb);
    else passed++;
  endtask

  task automatic test_bypass();
    rd_exp_t e;
    logic [WIDTH-1:0] c3;
    c3 = {30{8'hC3}};
    drive(1, 7, 1, 7, 4'b0010, c3, 0);
    e = sb.pop_front();
    checks++;
    if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb)
      $display("FAIL bypass_sb: got %h/%b %h/%b expected %h/%b %h/%b",
               rd_b, rv_b, rd_nb, rv_nb, e.d_b, e.v_b, e.d_nb, e.v_nb);
    else passed++;
    checks++;
    if (rd_b[LW +: LW] !== c3[LW +: LW] || rv_b !== 1'b1 || rd_nb !== '0 || rv_nb !== 1'b0)
      $display("FAIL bypass_lane1: got lane1=%h v=%b nb_v=%b expected lane1=%h v=1 nb_v=0",
               rd_b[LW +: LW], rv_b, rv_nb, c3[LW +: LW]);
    else passed++;
    checks++;
    if (cnt_b !== CW'(2) || cnt_nb !== CW'(2))
      $display("FAIL bypass_count: got %0d/%0d expected 2", cnt_b, cnt_nb);
    else passed++;
  endtask

  // Fill every entry while reading back the previous cycle's write.
  task automatic test_back_to_back();
    rd_exp_t e;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(i > 0, i - 1, 1, i % DEPTH, 4'b1111, rnd_data(), 0);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb)
          $display("FAIL b2b_read[%0d]: got %h/%b expected %h/%b", i - 1, rd_b, rv_b,
                   e.d_b, e.v_b);
        else passed++;
      end
    end
    checks++;
    if (cnt_b !== CW'(DEPTH) || cnt_nb !== CW'(DEPTH) || m_count != DEPTH)
      $display("FAIL full_count: got %0d/%0d expected %0d", cnt_b, cnt_nb, DEPTH);
    else passed++;
    drive(0, 0, 1, 5, 4'b0000, rnd_data(), 0);
    drive(1, 45, 1, 45, 4'b1111, rnd_data(), 0);
    e = sb.pop_front();
    checks++;
    if (rd_b !== '0 || rv_b !== 1'b0 || rd_nb !== '0 || rv_nb !== 1'b0 || e.v_b !== 1'b0)
      $display("FAIL oob_read: got %h/%b expected 0/0", rd_b, rv_b);
    else passed++;
    for (int a = 0; a < 6; a += 5) begin
      drive(1, a, 0, 0, '0, '0, 0);
      e = sb.pop_front();
      checks++;
      if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb)
        $display("FAIL reread[%0d]: got %h/%b expected %h/%b", a, rd_b, rv_b, e.d_b, e.v_b);
      else passed++;
    end
    checks++;
    if (cnt_b !== CW'(DEPTH) || cnt_nb !== CW'(DEPTH))
      $display("FAIL count_saturated: got %0d/%0d expected %0d", cnt_b, cnt_nb, DEPTH);
    else passed++;
  endtask

  task automatic test_flush();
    rd_exp_t e;
    int edges;
    drive(1, 2, 1, 2, 4'b1111, rnd_data(), 1);
    e = sb.pop_front();
    checks++;
    if (rd_b !== e.d_b || rv_b !== 1'b1 || rd_nb !== e.d_nb || rv_nb !== 1'b1)
      $display("FAIL flush_edge_read: got %h/%b expected %h/1", rd_b, rv_b, e.d_b);
    else passed++;
    checks++;
    if (cnt_b !== '0 || cnt_nb !== '0 || busy_b !== 1'b1 || busy_nb !== 1'b1)
      $display("FAIL flush_state: count=%0d busy=%b expected count=0 busy=1", cnt_b, busy_b);
    else passed++;
    drive(0, 0, 1, 4, 4'b1111, rnd_data(), 0);
    repeat (19) drive(0, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 1);
    edges = 0;
    while (busy_b === 1'b1 && edges < 100) begin
      drive(0, 0, 0, 0, '0, '0, 0);
      edges++;
    end
    checks++;
    if (edges != DEPTH) $display("FAIL reflush_busy_len: got %0d expected %0d", edges, DEPTH);
    else passed++;
    for (int a = 2; a <= 4; a += 2) begin
      drive(1, a, 0, 0, '0, '0, 0);
      e = sb.pop_front();
      checks++;
      if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== '0 || rv_nb !== 1'b0)
        $display("FAIL post_flush_read[%0d]: got %h/%b expected 0/0", a, rd_b, rv_b);
      else passed++;
    end
    checks++;
    if (cnt_b !== '0 || cnt_nb !== '0)
      $display("FAIL post_flush_count: got %0d/%0d expected 0", cnt_b, cnt_nb);
    else passed++;
  endtask

  task automatic test_async_reset();
    rd_exp_t e;
    int edges;
    drive(0, 0, 1, 1, 4'b1111, rnd_data() | WIDTH'(1), 0);
    drive(1, 1, 0, 0, '0, '0, 0);
    e = sb.pop_front();
    checks++;
    if (rd_b !== e.d_b || rv_b !== 1'b1 || rd_nb !== e.d_nb || rv_nb !== 1'b1)
      $display("FAIL pre_reset_read: got %h/%b expected %h/1", rd_b, rv_b, e.d_b);
    else passed++;
    drive(0, 0, 0, 0, '0, '0, 1);
    repeat (10) drive(0, 0, 0, 0, '0, '0, 0);
    checks++;
    if (rd_b !== e.d_b || rd_nb !== e.d_nb || m_idx != 10)
      $display("FAIL read_hold: got %h expected %h", rd_b, e.d_b);
    else passed++;
    #3 reset = 1'b1;
    #1;
    checks++;
    if (busy_b !== 1'b1 || busy_nb !== 1'b1 || cnt_b !== '0 || cnt_nb !== '0 ||
        rd_b !== '0 || rv_b !== 1'b0 || rd_nb !== '0 || rv_nb !== 1'b0)
      $display("FAIL async_reset: busy=%b count=%0d data=%h expected busy=1 count=0 data=0",
               busy_b, cnt_b, rd_b);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    edges = 0;
    while (busy_b === 1'b1 && edges < 100) begin
      drive(0, 0, 0, 0, '0, '0, 0);
      edges++;
    end
    checks++;
    if (edges != DEPTH) $display("FAIL rereset_busy_len: got %0d expected %0d", edges, DEPTH);
    else passed++;
    drive(0, 0, 1, 9, 4'b1001, rnd_data(), 0);
    drive(1, 9, 0, 0, '0, '0, 0);
    e = sb.pop_front();
    checks++;
    if (rd_b !== e.d_b || rv_b !== e.v_b || rd_nb !== e.d_nb || rv_nb !== e.v_nb ||
        cnt_b !== CW'(1) || cnt_nb !== CW'(1))
      $display("FAIL post_reset_write: got %h/%b count=%0d expected %h/%b count=1",
               rd_b, rv_b, cnt_b, e.d_b, e.v_b);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mask();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
